// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
//   Shared definitions for the multi-cycle MIPS control unit and its
//   opcode class decoder:
//     state_e    - control FSM states
//     opclass_e  - instruction classes latched in DECODE
//     ALU_*      - alu_op encodings
//     SRCB_*     - alu_src_b encodings
//     PC_*       - pc_src encodings
//     OP_*       - opcode patterns (full value or high-order prefix)
//     opclass_of - opcode to class map
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  // CL_RTYPE is encoded as 0 so that the reset value of the class
  // register is all-zeros.
  typedef enum logic [2:0] {
    CL_RTYPE   = 3'd0,
    CL_IALU    = 3'd1,
    CL_BRANCH  = 3'd2,
    CL_JUMP    = 3'd3,
    CL_LOAD    = 3'd4,
    CL_STORE   = 3'd5,
    CL_ILLEGAL = 3'd6
  } opclass_e;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;
  localparam logic [1:0] ALU_IMM   = 2'd3;

  localparam logic [1:0] SRCB_RT    = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_SIMM  = 2'd2;
  localparam logic [1:0] SRCB_SHIMM = 2'd3;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  localparam logic [5:0] OP_RTYPE      = 6'b000000;
  localparam logic [2:0] OP_IALU_PFX   = 3'b001;
  localparam logic [3:0] OP_BRANCH_PFX = 4'b0001;
  localparam logic [4:0] OP_JUMP_PFX   = 5'b00001;
  localparam logic [2:0] OP_LOAD_PFX   = 3'b100;
  localparam logic [2:0] OP_STORE_PFX  = 3'b101;

  function automatic opclass_e opclass_of(input logic [5:0] op);
    opclass_e c;
    if (op == OP_RTYPE)                c = CL_RTYPE;
    else if (op[5:3] == OP_IALU_PFX)   c = CL_IALU;
    else if (op[5:2] == OP_BRANCH_PFX) c = CL_BRANCH;
    else if (op[5:1] == OP_JUMP_PFX)   c = CL_JUMP;
    else if (op[5:3] == OP_LOAD_PFX)   c = CL_LOAD;
    else if (op[5:3] == OP_STORE_PFX)  c = CL_STORE;
    else                               c = CL_ILLEGAL;
    return c;
  endfunction

endpackage

// File: rtl/mips_opclass_decode.sv
// mips_opclass_decode
//   Combinational opcode-to-class map, shared with the datapath ALU decoder.
//   Ports:
//     opcode   in  [OPCODE_W-1:0]  instruction opcode field
//     op_class out opclass_e       decoded instruction class
module mips_opclass_decode
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode,
  output opclass_e            op_class
);

  logic [5:0] op6;

  assign op6 = 6'(opcode);

  always_comb begin
    op_class = opclass_of(op6);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Multi-cycle MIPS control unit. Walks FETCH/DECODE/EXEC/MEM/WB for each
//   instruction, drives datapath enables and ALU/mux selects, handshakes with
//   the shared instruction/data memory port and counts retired instructions.
//
//   Ports:
//     clk, rst_n            clock, synchronous active-low reset
//     run                   start fetching (sampled in IDLE only)
//     opcode, funct         IR fields (funct is used by the datapath ALU
//                           decoder, not for sequencing)
//     mem_ready             memory completes the current request this cycle
//     mem_req, mem_write    memory request / store
//     ir_write, pc_write    IR load, unconditional PC update
//     pc_write_cond         PC update on ALU zero
//     pc_src, alu_src_a, alu_src_b, alu_op   datapath selects
//     reg_write, reg_dst, mem_to_reg         register file write-back
//     illegal               sticky undecodable-opcode flag
//     instr_count           retired instruction count (wraps)
//     trap                  one-cycle trap pulse (MCTL_TRAP_EN builds only)
//
//   Build option: define MCTL_TRAP_EN to route illegal opcodes through TRAP
//   instead of retiring them as a NOP.
//
//   state  | meaning
//   IDLE   | waiting for run
//   FETCH  | instruction read, PC+4; held until mem_ready
//   DECODE | class latched, branch target precomputed
//   EXEC   | ALU op per class; branch/jump retire here
//   MEM    | load/store access; held until mem_ready
//   WB     | register write-back, retire
//   TRAP   | jump to trap vector, no retirement
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int FUNCT_W  = 6,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_write,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_src,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                illegal,
  output logic [CNT_W-1:0]    instr_count
`ifdef MCTL_TRAP_EN
  ,
  output logic                trap
`endif
);

  state_e             state_q, state_d;
  opclass_e           class_q, class_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               illegal_q, illegal_d;
  logic               retire;
  opclass_e           dec_class;
  logic               funct_unused;

  assign funct_unused = ^funct;

  mips_opclass_decode #(
    .OPCODE_W (OPCODE_W)
  ) u_opclass_decode (
    .opcode   (opcode),
    .op_class (dec_class)
  );

  always_comb begin
    state_d   = state_q;
    class_d   = class_q;
    count_d   = count_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem_ready) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        class_d = dec_class;
        if (dec_class == CL_ILLEGAL) begin
          illegal_d = 1'b1;
`ifdef MCTL_TRAP_EN
          state_d   = ST_TRAP;
`else
          retire    = 1'b1;
          state_d   = ST_FETCH;
`endif
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (class_q)
          CL_RTYPE, CL_IALU:  state_d = ST_WB;
          CL_LOAD, CL_STORE:  state_d = ST_MEM;
          CL_BRANCH, CL_JUMP: begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
          default:            state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (mem_ready) begin
          if (class_q == CL_LOAD) begin
            state_d = ST_WB;
          end else begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_WB: begin
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_TRAP: begin
        state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
    if (retire) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      class_q   <= CL_RTYPE;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

  // Moore outputs; only the memory handshake terms look at mem_ready.
  always_comb begin
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = PC_PLUS4;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    alu_op        = ALU_ADD;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      ST_DECODE: begin
        alu_src_b = SRCB_SHIMM;
      end
      ST_EXEC: begin
        case (class_q)
          CL_RTYPE: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_RT;
            alu_op    = ALU_FUNCT;
          end
          CL_IALU: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_SIMM;
            alu_op    = ALU_IMM;
          end
          CL_LOAD, CL_STORE: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_SIMM;
            alu_op    = ALU_ADD;
          end
          CL_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_src_b     = SRCB_RT;
            alu_op        = ALU_SUB;
            pc_write_cond = 1'b1;
            pc_src        = PC_BRANCH;
          end
          CL_JUMP: begin
            pc_write = 1'b1;
            pc_src   = PC_JUMP;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        mem_req   = 1'b1;
        mem_write = (class_q == CL_STORE);
      end
      ST_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (class_q == CL_RTYPE);
        mem_to_reg = (class_q == CL_LOAD);
      end
      ST_TRAP: begin
        pc_write = 1'b1;
        pc_src   = PC_JUMP;
      end
      default: ;
    endcase
  end

  assign illegal     = illegal_q;
  assign instr_count = count_q;

`ifdef MCTL_TRAP_EN
  assign trap = (state_q == ST_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
//   Randomized bench for multicycle_ctrl. Each instruction is modelled as a
//   list of phases derived from its class; FETCH and MEM phases repeat while
//   mem_ready is low. Expected outputs per phase come from the control table.
//   Build with MCTL_TRAP_EN defined to cover the trap variant.
module tb_multicycle_ctrl;

  localparam int CW = 4;

  localparam int K_R = 0, K_I = 1, K_B = 2, K_J = 3, K_L = 4, K_S = 5, K_X = 6;

  typedef enum int {PH_F, PH_D, PH_E, PH_M, PH_W, PH_T} ph_t;

  logic          clk = 1'b0;
  logic          rst_n, run, mem_ready;
  logic [5:0]    opcode, funct;
  logic          mem_req, mem_write, ir_write, pc_write, pc_write_cond;
  logic [1:0]    pc_src, alu_src_b, alu_op;
  logic          alu_src_a, reg_write, reg_dst, mem_to_reg, illegal;
  logic [CW-1:0] instr_count;

`ifdef MCTL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
  logic trap;
`else
  localparam bit TRAP_EN = 1'b0;
  wire  trap = 1'b0;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl #(
    .OPCODE_W (6),
    .FUNCT_W  (6),
    .CNT_W    (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .run           (run),
    .opcode        (opcode),
    .funct         (funct),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_src        (pc_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .illegal       (illegal),
    .instr_count   (instr_count)
`ifdef MCTL_TRAP_EN
    ,
    .trap          (trap)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  // reference model state
  ph_t           pq[$];
  logic [5:0]    op_q[$];
  bit            idle;
  int            cls;
  logic          illegal_m;
  logic [CW-1:0] cnt_m;
  logic [5:0]    cur_op;
  int            load_stall_left;

  function automatic int classify(input logic [5:0] op);
    int v = int'(op);
    if (v == 0)              return K_R;
    if (v >= 8  && v <= 15)  return K_I;
    if (v >= 4  && v <= 7)   return K_B;
    if (v >= 2  && v <= 3)   return K_J;
    if (v >= 32 && v <= 39)  return K_L;
    if (v >= 40 && v <= 47)  return K_S;
    return K_X;
  endfunction

  function automatic logic [5:0] rand_op();
    int k = $urandom_range(0, 8);
    int v;
    case (k)
      0: v = 0;
      1: v = 8  + $urandom_range(0, 7);
      2: v = 4  + $urandom_range(0, 3);
      3: v = 2  + $urandom_range(0, 1);
      4: v = 32 + $urandom_range(0, 7);
      5: v = 40 + $urandom_range(0, 7);
      6: v = 63;
      7: v = $urandom_range(0, 63);
      default: v = 35;
    endcase
    return 6'(v);
  endfunction

  task automatic start_instr();
    if (op_q.size() > 0) cur_op = op_q.pop_front();
    else                 cur_op = rand_op();
    cls = classify(cur_op);
    pq.delete();
    case (cls)
      K_R, K_I: pq = '{PH_F, PH_D, PH_E, PH_W};
      K_L:      pq = '{PH_F, PH_D, PH_E, PH_M, PH_W};
      K_S:      pq = '{PH_F, PH_D, PH_E, PH_M};
      K_B, K_J: pq = '{PH_F, PH_D, PH_E};
      default:  if (TRAP_EN) pq = '{PH_F, PH_D, PH_T};
                else         pq = '{PH_F, PH_D};
    endcase
  endtask

  // {mem_req, mem_write, ir_write, pc_write, pc_write_cond, pc_src,
  //  alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, illegal, trap}
  function automatic logic [16:0] exp_out(input bit is_idle, input ph_t ph, input int c,
                                          input logic mr, input logic ill);
    logic mq = 0, mw = 0, iw = 0, pw = 0, pwc = 0, sa = 0, rw = 0, rd = 0, m2r = 0, tr = 0;
    logic [1:0] ps = 0, sb = 0, ao = 0;
    if (!is_idle) begin
      case (ph)
        PH_F: begin mq = 1; sb = 1; iw = mr; pw = mr; end
        PH_D: sb = 3;
        PH_E: begin
          if (c == K_R)                 begin sa = 1; sb = 0; ao = 2; end
          else if (c == K_I)            begin sa = 1; sb = 2; ao = 3; end
          else if (c == K_L || c == K_S) begin sa = 1; sb = 2; ao = 0; end
          else if (c == K_B)            begin sa = 1; sb = 0; ao = 1; pwc = 1; ps = 1; end
          else if (c == K_J)            begin pw = 1; ps = 2; end
        end
        PH_M: begin mq = 1; mw = (c == K_S); end
        PH_W: begin rw = 1; rd = (c == K_R); m2r = (c == K_L); end
        PH_T: begin pw = 1; ps = 2; tr = 1; end
        default: ;
      endcase
    end
    return {mq, mw, iw, pw, pwc, ps, sa, sb, ao, rw, rd, m2r, ill, tr};
  endfunction

  function automatic logic [16:0] obs_out();
    return {mem_req, mem_write, ir_write, pc_write, pc_write_cond, pc_src,
            alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, illegal, trap};
  endfunction

  function automatic logic pick_mr_directed();
    if (!idle && pq.size() > 0 && pq[0] == PH_M && cls == K_L && load_stall_left > 0) begin
      load_stall_left--;
      return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic do_cycle(input logic mr, input logic rn);
    ph_t ph;
    string tag;
    @(negedge clk);
    opcode    = cur_op;
    mem_ready = mr;
    run       = rn;
    funct     = 6'($urandom);
    #1;
    ph  = (pq.size() > 0) ? pq[0] : PH_F;
    tag = idle ? "out_IDLE" : {"out_", ph.name()};
    chk(tag, 32'(obs_out()), 32'(exp_out(idle, ph, cls, mr, illegal_m)));
    chk("instr_count", 32'(instr_count), 32'(cnt_m));
    if (idle) begin
      if (rn) begin
        idle = 0;
        start_instr();
      end
    end else if (!((ph == PH_F || ph == PH_M) && !mr)) begin
      if (ph == PH_D && cls == K_X) illegal_m = 1'b1;
      void'(pq.pop_front());
      if (pq.size() == 0) begin
        if (ph != PH_T) cnt_m = cnt_m + 1'b1;
        start_instr();
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    run       = 1'b0;
    mem_ready = 1'($urandom);
    @(negedge clk);
    #1;
    chk("rst_outputs", 32'(obs_out()), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    rst_n     = 1'b1;
    idle      = 1;
    pq.delete();
    illegal_m = 1'b0;
    cnt_m     = '0;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; opcode = '0; funct = '0;
    cur_op = '0; idle = 1; cls = K_R; illegal_m = 1'b0; cnt_m = '0;
    load_stall_left = 0;

    // directed: RTYPE, LOAD with two MEM stalls, STORE, BRANCH, JUMP, illegal
    do_reset();
    op_q = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b111111};
    load_stall_left = 2;
    for (int i = 0; i < 30; i++) do_cycle(pick_mr_directed(), 1'b1);

    // reset while a load sits in MEM
    op_q.push_back(6'b100011);
    load_stall_left = 3;
    for (int i = 0; i < 60; i++) begin
      do_cycle(pick_mr_directed(), 1'b1);
      if (!idle && cls == K_L && pq.size() > 0 && pq[0] == PH_M) break;
    end
    do_reset();

    // counter wrap: sixteen jumps on a 4-bit counter
    op_q.delete();
    for (int i = 0; i < 16; i++) op_q.push_back(6'b000010);
    for (int i = 0; i < 60; i++) do_cycle(1'b1, 1'b1);

    // randomized traffic with stalls, run toggling and occasional resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else do_cycle(($urandom_range(0, 9) < 7), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
